// File: rtl/if_pc_fetch_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes (as driven by the decoder),
// FSM states, the default reset PC and the branch-offset helper.
package if_pc_fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_op_t;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Word-scaled, sign-extended 16-bit branch displacement.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/if_pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the hand-off to decode.
// master = the fetch stage, slave = memory and decode/datapath side.
interface if_pc_fetch_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [1:0]  npc_op;
   logic [31:0] rs_data;

   modport master (
      output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, npc_op, rs_data
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, npc_op, rs_data
   );

endinterface

// File: rtl/if_npc_calc.sv
// Combinational next-PC: PLUS4, BRANCH, JUMP, and jump-register when IF_JR_EN is defined
// (otherwise code 11 falls back to PLUS4). All arithmetic wraps modulo 2^32.
module if_npc_calc
   import if_pc_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] jidx,
   input  logic [1:0]  npc_op,
`ifdef IF_JR_EN
   input  logic [31:0] rs_data,
`endif
   output logic [31:0] npc
);

   logic [31:0] pc4;
   logic [31:0] br_tgt;
   logic [31:0] jmp_tgt;

   assign pc4     = pc + 32'd4;
   assign br_tgt  = pc4 + branch_offset(jidx[15:0]);
   // The jump region comes from the delay-slot address, not the jump itself.
   assign jmp_tgt = {pc4[31:28], jidx, 2'b00};

   always_comb begin
      npc = pc4;
      case (npc_op_t'(npc_op))
         NPC_BRANCH: npc = br_tgt;
         NPC_JUMP:   npc = jmp_tgt;
`ifdef IF_JR_EN
         NPC_JR:     npc = rs_data & 32'hFFFF_FFFC;
`endif
         default:    npc = pc4;
      endcase
   end

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction fetch: one outstanding imem request, holds instr/pc for decode until retire,
// then loads the computed next PC. Best case 3 cycles/instr. Optional IF_JR_EN adds jump-register.
module if_pc_fetch
   import if_pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic          clk,
   input  logic          rst,
   if_pc_fetch_if.master bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_vld;
   logic [31:0] npc;
   logic        capture;
   logic        retire;

   assign capture = (state == S_WAIT) && bus.imem_rsp_valid;
   assign retire  = (state == S_HOLD) && bus.if_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (bus.imem_req_ready) state_nxt = S_WAIT;
         S_WAIT:  if (bus.imem_rsp_valid) state_nxt = S_HOLD;
         S_HOLD:  if (bus.if_ready)       state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC_ALIGNED;
         instr     <= 32'd0;
         instr_vld <= 1'b0;
      end else begin
         if (capture) begin
            instr     <= bus.imem_rsp_data;
            instr_vld <= 1'b1;
         end
         if (retire) begin
            pc        <= npc;
            instr_vld <= 1'b0;
         end
      end
   end

   if_npc_calc u_npc_calc (
      .pc      (pc),
      .jidx    (instr[25:0]),
      .npc_op  (bus.npc_op),
`ifdef IF_JR_EN
      .rs_data (bus.rs_data),
`endif
      .npc     (npc)
   );

   // Request is suppressed during the reset cycle itself.
   assign bus.imem_req_valid = (state == S_REQ) && !rst;
   assign bus.imem_addr      = {pc[31:2], 2'b00};
   assign bus.if_valid       = instr_vld;
   assign bus.if_instr       = instr;
   assign bus.if_pc          = pc;

   a_pc_stable: assert property (@(posedge clk) disable iff (rst)
      !retire |=> $stable(pc));

   a_req_held: assert property (@(posedge clk) disable iff (rst)
      (bus.imem_req_valid && !bus.imem_req_ready) |=> bus.imem_req_valid && $stable(bus.imem_addr));

   a_vld_matches_hold: assert property (@(posedge clk) disable iff (rst)
      bus.if_valid == (state == S_HOLD));

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: table of fetch/retire vectors plus stall, spurious-response
// and reset-during-wait sequences. Expected jump-register results depend on IF_JR_EN.
module tb_if_pc_fetch;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   int   n_req;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] nxt;
   } vec_t;

   vec_t vecs[10];

   if_pc_fetch_if bus ();

   if_pc_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial n_req = 0;
   always @(posedge clk)
      if (bus.imem_req_valid && bus.imem_req_ready) n_req <= n_req + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      chk("req_valid_in_req", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("req_addr", bus.imem_addr, v.pc);
      chk("if_valid_low_req", {31'd0, bus.if_valid}, 32'd0);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      #1;
      chk("req_valid_in_wait", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("if_valid_low_wait", {31'd0, bus.if_valid}, 32'd0);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = v.instr;
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      #1;
      chk("if_valid_hold", {31'd0, bus.if_valid}, 32'd1);
      chk("if_instr", bus.if_instr, v.instr);
      chk("if_pc", bus.if_pc, v.pc);
      bus.if_ready = 1'b1;
      bus.npc_op   = v.op;
      bus.rs_data  = v.rs;
      tick();
      bus.if_ready = 1'b0;
      bus.npc_op   = 2'b00;
      bus.rs_data  = 32'd0;
      #1;
      chk("if_valid_after_retire", {31'd0, bus.if_valid}, 32'd0);
      chk("next_addr", bus.imem_addr, v.nxt);
   endtask

   initial begin
      logic [31:0] p;
      int          n0;

      n_total = 0;
      n_pass  = 0;

      vecs[0] = '{32'h0000_3000, 32'h2008_0005, 2'b00, 32'd0, 32'h0000_3004};
      vecs[1] = '{32'h0000_3004, 32'h1000_FFFF, 2'b01, 32'd0, 32'h0000_3004};
      vecs[2] = '{32'h0000_3004, 32'h1000_FFFF, 2'b00, 32'd0, 32'h0000_3008};
      vecs[3] = '{32'h0000_3008, 32'h0800_0C10, 2'b10, 32'd0, 32'h0000_3040};
      vecs[4] = '{32'h0000_3040, 32'h1000_F3EE, 2'b01, 32'd0, 32'hFFFF_FFFC};
      vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 32'd0, 32'h0000_0000};
      vecs[6] = '{32'h0000_0000, 32'h0BFF_FFFF, 2'b10, 32'd0, 32'h0FFF_FFFC};
`ifdef IF_JR_EN
      vecs[7] = '{32'h0FFF_FFFC, 32'h0000_0008, 2'b11, 32'h0040_0023, 32'h0040_0020};
      vecs[8] = '{32'h0040_0020, 32'h0800_0001, 2'b10, 32'd0, 32'h0000_0004};
      vecs[9] = '{32'h0000_0004, 32'h1000_0010, 2'b01, 32'd0, 32'h0000_0048};
`else
      vecs[7] = '{32'h0FFF_FFFC, 32'h0000_0008, 2'b11, 32'h0040_0023, 32'h1000_0000};
      vecs[8] = '{32'h1000_0000, 32'h0800_0001, 2'b10, 32'd0, 32'h1000_0004};
      vecs[9] = '{32'h1000_0004, 32'h1000_0010, 2'b01, 32'd0, 32'h1000_0048};
`endif

      rst                = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.if_ready       = 1'b0;
      bus.npc_op         = 2'b00;
      bus.rs_data        = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'h0000_3000);
      chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'd0);
      rst = 1'b0;
      #1;
      chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("first_req_addr", bus.imem_addr, 32'h0000_3000);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Request stall with a spurious response, slow response, then decode backpressure.
      p  = vecs[9].nxt;
      n0 = n_req;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("stall_req_addr", bus.imem_addr, p);
         chk("stall_if_valid", {31'd0, bus.if_valid}, 32'd0);
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("slow_rsp_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
         chk("slow_rsp_if_valid", {31'd0, bus.if_valid}, 32'd0);
         chk("slow_rsp_addr", bus.imem_addr, p);
         tick();
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h3C01_1234;
      tick();
      bus.imem_rsp_data  = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         chk("bp_if_valid", {31'd0, bus.if_valid}, 32'd1);
         chk("bp_if_instr", bus.if_instr, 32'h3C01_1234);
         chk("bp_if_pc", bus.if_pc, p);
         chk("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
         tick();
      end
      chk("stall_request_count", n_req - n0, 32'd1);
      bus.imem_rsp_valid = 1'b0;
      bus.if_ready       = 1'b1;
      bus.npc_op         = 2'b00;
      tick();
      bus.if_ready = 1'b0;
      #1;
      chk("bp_next_addr", bus.imem_addr, p + 32'd4);
      chk("bp_if_valid_clear", {31'd0, bus.if_valid}, 32'd0);

      // Reset while waiting for a response; a late response afterwards must be ignored.
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("midrst_if_pc", bus.if_pc, 32'h0000_3000);
      chk("midrst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      rst                = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h1111_1111;
      #1;
      chk("postrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("postrst_req_addr", bus.imem_addr, 32'h0000_3000);
      tick();
      bus.imem_rsp_valid = 1'b0;
      #1;
      chk("postrst_still_req", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("postrst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("postrst_if_instr", bus.if_instr, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
